// File: rtl/riscv_pkg.sv
// Shared definitions for the EX-stage branch resolution logic.
//   - B-type funct3 encodings
//   - resolve FSM state type
//   - 2-bit saturating predictor counter type, reset value and update helper
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef logic [1:0] ctr2_t;

    // Weakly not taken: predictor MSB reads 0 out of reset.
    localparam ctr2_t WNT = 2'b01;

    // Saturating step of a 2-bit predictor counter.
    function automatic ctr2_t ctr2_step(input ctr2_t ctr, input logic taken);
        ctr2_t res;
        res = ctr;
        if (taken && ctr != 2'b11) begin
            res = ctr + 2'd1;
        end else if (!taken && ctr != 2'b00) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_bht.sv
// bht_2bit: branch history table of 2-bit saturating counters.
//   clk, rst_n  : clock, asynchronous active-low reset (all entries -> WNT)
//   rd_idx      : combinational lookup index
//   rd_ctr      : counter value at rd_idx (pre-update value on a same-cycle write)
//   upd_en      : apply a saturating update this cycle
//   upd_idx     : entry to update
//   upd_taken   : direction of the update (1 = increment, 0 = decrement)
module bht_2bit
    import riscv_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output ctr2_t            rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    ctr2_t ctr_reg [ENTRIES];

    // One register per entry so every counter resets asynchronously to WNT.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctr_reg[gi] <= WNT;
                end else if (upd_en && upd_idx == IDX_W'(gi)) begin
                    ctr_reg[gi] <= ctr2_step(ctr_reg[gi], upd_taken);
                end
            end
        end
    endgenerate

    // No write bypass: a same-cycle lookup sees the old value.
    assign rd_ctr = ctr_reg[rd_idx];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: EX-stage branch/jump resolution next to the comparator.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_pc_f / o_pred_taken_f : fetch-side BHT lookup
//   i_*_e                 : EX instruction info (valid, type, funct3, prediction, PC, target)
//   i_br_less/i_br_equal  : comparator flags; o_br_un selects unsigned compare
//   i_stall               : EX hold
//   o_redirect, o_redirect_pc, o_flush_d, o_flush_e : registered one-cycle redirect
//   o_illegal_br          : valid B-type with reserved funct3
//   o_br_cnt, o_mispred_cnt : resolved transfer / mispredict counters
module branch_resolve_ctrl
    import riscv_pkg::*;
#(
    parameter int BHT_IDX_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_pc_f,
    output logic             o_pred_taken_f,
    input  logic             i_valid_e,
    input  logic             i_is_branch_e,
    input  logic             i_is_jal_e,
    input  logic             i_is_jalr_e,
    input  logic [2:0]       i_funct3_e,
    input  logic             i_pred_taken_e,
    input  logic [31:0]      i_pc_e,
    input  logic [31:0]      i_target_e,
    input  logic             i_br_less,
    input  logic             i_br_equal,
    input  logic             i_stall,
    output logic             o_br_un,
    output logic             o_redirect,
    output logic [31:0]      o_redirect_pc,
    output logic             o_flush_d,
    output logic             o_flush_e,
    output logic             o_illegal_br,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    state_t            state_reg;
    logic              redirect_reg;
    logic              flush_reg;
    logic [31:0]       redirect_pc_reg;
    logic [CNT_W-1:0]  br_cnt_reg;
    logic [CNT_W-1:0]  mispred_cnt_reg;

    logic              br_taken;
    logic              br_legal;
    logic              actual_taken;
    logic              resolve;
    logic              mispredict;
    logic              bht_upd;
    ctr2_t             pred_ctr;

    // funct3[1] distinguishes BLTU/BGEU from BLT/BGE.
    assign o_br_un = i_funct3_e[1];

    always_comb begin
        br_taken = 1'b0;
        br_legal = 1'b1;
        case (i_funct3_e)
            F3_BEQ:  br_taken = i_br_equal;
            F3_BNE:  br_taken = !i_br_equal;
            F3_BLT:  br_taken = i_br_less;
            F3_BGE:  br_taken = !i_br_less;
            F3_BLTU: br_taken = i_br_less;
            F3_BGEU: br_taken = !i_br_less;
            default: br_legal = 1'b0;
        endcase
    end

    assign o_illegal_br = i_valid_e && i_is_branch_e && !br_legal;

    assign actual_taken = i_is_jal_e || i_is_jalr_e || (i_is_branch_e && br_taken);

    // Instructions reaching EX during FLUSH are being killed, hence the IDLE qualifier.
    assign resolve = i_valid_e && !i_stall && (state_reg == IDLE) &&
                     (i_is_branch_e || i_is_jal_e || i_is_jalr_e);

    // JALR has no target prediction, so it always redirects.
    assign mispredict = resolve && ((actual_taken != i_pred_taken_e) || i_is_jalr_e);

    assign bht_upd = resolve && i_is_branch_e && br_legal && !i_is_jal_e && !i_is_jalr_e;

    bht_2bit #(
        .IDX_W(BHT_IDX_W)
    ) u_bht (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .rd_idx    (i_pc_f[BHT_IDX_W+1:2]),
        .rd_ctr    (pred_ctr),
        .upd_en    (bht_upd),
        .upd_idx   (i_pc_e[BHT_IDX_W+1:2]),
        .upd_taken (actual_taken)
    );

    assign o_pred_taken_f = pred_ctr[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg       <= IDLE;
            redirect_reg    <= 1'b0;
            flush_reg       <= 1'b0;
            redirect_pc_reg <= '0;
            br_cnt_reg      <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mispredict) begin
                        state_reg       <= FLUSH;
                        redirect_reg    <= 1'b1;
                        flush_reg       <= 1'b1;
                        redirect_pc_reg <= actual_taken ? i_target_e : (i_pc_e + 32'd4);
                    end
                end
                // Leaves FLUSH unconditionally, stall or not, so the redirect is never lost.
                FLUSH: begin
                    state_reg    <= IDLE;
                    redirect_reg <= 1'b0;
                    flush_reg    <= 1'b0;
                end
                default: begin
                    state_reg    <= IDLE;
                    redirect_reg <= 1'b0;
                    flush_reg    <= 1'b0;
                end
            endcase
            if (resolve) begin
                br_cnt_reg <= br_cnt_reg + 1'b1;
            end
            if (mispredict) begin
                mispred_cnt_reg <= mispred_cnt_reg + 1'b1;
            end
        end
    end

    assign o_redirect    = redirect_reg;
    assign o_flush_d     = flush_reg;
    assign o_flush_e     = flush_reg;
    assign o_redirect_pc = redirect_pc_reg;
    assign o_br_cnt      = br_cnt_reg;
    assign o_mispred_cnt = mispred_cnt_reg;

    // Only the index bits of the fetch PC select a BHT entry.
    logic unused_pc_f_bits;
    assign unused_pc_f_bits = ^{i_pc_f[31:BHT_IDX_W+2], i_pc_f[1:0]};

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed table, reset-in-FLUSH
// sequence, then randomized traffic against a behavioural model.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic        valid_e, is_branch_e, is_jal_e, is_jalr_e;
    logic [2:0]  funct3_e;
    logic        pred_taken_e;
    logic [31:0] pc_e, target_e;
    logic        br_less, br_equal, stall;
    logic        br_un, redirect, flush_d, flush_e, illegal_br;
    logic [31:0] redirect_pc, br_cnt, mispred_cnt;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.BHT_IDX_W(4), .CNT_W(32)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_pc_f         (pc_f),
        .o_pred_taken_f (pred_taken_f),
        .i_valid_e      (valid_e),
        .i_is_branch_e  (is_branch_e),
        .i_is_jal_e     (is_jal_e),
        .i_is_jalr_e    (is_jalr_e),
        .i_funct3_e     (funct3_e),
        .i_pred_taken_e (pred_taken_e),
        .i_pc_e         (pc_e),
        .i_target_e     (target_e),
        .i_br_less      (br_less),
        .i_br_equal     (br_equal),
        .i_stall        (stall),
        .o_br_un        (br_un),
        .o_redirect     (redirect),
        .o_redirect_pc  (redirect_pc),
        .o_flush_d      (flush_d),
        .o_flush_e      (flush_e),
        .o_illegal_br   (illegal_br),
        .o_br_cnt       (br_cnt),
        .o_mispred_cnt  (mispred_cnt)
    );

    typedef struct {
        logic        valid, br, jal, jalr;
        logic [2:0]  f3;
        logic        pred;
        logic [31:0] pc, tgt;
        logic        less, eq, stall;
        logic [31:0] pc_f;
        logic        exp_redir;
        logic [31:0] exp_rpc, exp_br, exp_mis;
        logic        exp_pf;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: predictor strengths 0..3, pending-flush flag, counters.
    int          m_bht [16];
    bit          m_flush;
    logic [31:0] m_rpc, m_br, m_mis;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_flush = 0; m_rpc = 0; m_br = 0; m_mis = 0;
    endtask

    function automatic bit cond_taken(input logic [2:0] f3, input logic less, input logic eq);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4, 3'd6: return less;
            3'd5, 3'd7: return !less;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge(input vec_t v);
        bit taken, legal, mis;
        if (m_flush) begin
            m_flush = 0;
        end else if (v.valid && !v.stall && (v.br || v.jal || v.jalr)) begin
            legal = !(v.f3 == 3'd2 || v.f3 == 3'd3);
            taken = (v.jal || v.jalr) ? 1'b1 : (v.br && cond_taken(v.f3, v.less, v.eq));
            mis   = (taken != v.pred) || v.jalr;
            m_br  = m_br + 1;
            if (v.br && legal && !v.jal && !v.jalr) begin
                if (taken) m_bht[v.pc[5:2]] = (m_bht[v.pc[5:2]] == 3) ? 3 : m_bht[v.pc[5:2]] + 1;
                else       m_bht[v.pc[5:2]] = (m_bht[v.pc[5:2]] == 0) ? 0 : m_bht[v.pc[5:2]] - 1;
            end
            if (mis) begin
                m_flush = 1;
                m_mis   = m_mis + 1;
                m_rpc   = taken ? v.tgt : v.pc + 32'd4;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        valid_e = v.valid; is_branch_e = v.br; is_jal_e = v.jal; is_jalr_e = v.jalr;
        funct3_e = v.f3; pred_taken_e = v.pred; pc_e = v.pc; target_e = v.tgt;
        br_less = v.less; br_equal = v.eq; stall = v.stall; pc_f = v.pc_f;
    endtask

    // One clock: comb checks before the edge, registered checks 1 time unit after it.
    task automatic step(input vec_t v, input bit use_exp, input bit verbose);
        drive(v);
        #1;
        chk("br_un", 32'(br_un), 32'(v.f3[1]));
        chk("illegal_br", 32'(illegal_br),
            32'(v.valid && v.br && (v.f3 == 3'd2 || v.f3 == 3'd3)));
        chk("pred_f_pre", 32'(pred_taken_f), 32'(m_bht[v.pc_f[5:2]] >= 2));
        @(posedge clk);
        model_edge(v);
        #1;
        chk("redirect", 32'(redirect), 32'(m_flush));
        chk("flush_d", 32'(flush_d), 32'(m_flush));
        chk("flush_e", 32'(flush_e), 32'(m_flush));
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("br_cnt", br_cnt, m_br);
        chk("mispred_cnt", mispred_cnt, m_mis);
        chk("pred_f_post", 32'(pred_taken_f), 32'(m_bht[v.pc_f[5:2]] >= 2));
        if (use_exp) begin
            chk("tbl_redirect", 32'(redirect), 32'(v.exp_redir));
            chk("tbl_redirect_pc", redirect_pc, v.exp_rpc);
            chk("tbl_br_cnt", br_cnt, v.exp_br);
            chk("tbl_mispred_cnt", mispred_cnt, v.exp_mis);
            chk("tbl_pred_f", 32'(pred_taken_f), 32'(v.exp_pf));
        end
        if (verbose)
            $display("txn pc=%h f3=%0d br=%0d jal=%0d jalr=%0d stall=%0d -> redir=%0d rpc=%h br_cnt=%0d mis=%0d",
                     v.pc, v.f3, v.br, v.jal, v.jalr, v.stall, redirect, redirect_pc, br_cnt, mispred_cnt);
    endtask

    vec_t tbl [13];
    vec_t v;

    initial begin
        // valid br jal jalr f3 pred pc tgt less eq stall pc_f | redir rpc br mis pf
        tbl[0]  = '{1,1,0,0,3'd0,1'b0,32'h100,32'h200,1'b0,1'b1,1'b0,32'h100, 1,32'h200,1,1,1};
        tbl[1]  = '{1,1,0,0,3'd1,1'b0,32'h104,32'h300,1'b0,1'b0,1'b0,32'h100, 0,32'h200,1,1,1};
        tbl[2]  = '{1,1,0,0,3'd6,1'b0,32'h100,32'h200,1'b0,1'b0,1'b0,32'h100, 0,32'h200,2,1,0};
        tbl[3]  = '{1,1,0,0,3'd1,1'b1,32'h108,32'h400,1'b0,1'b0,1'b1,32'h108, 0,32'h200,2,1,0};
        tbl[4]  = tbl[3];
        tbl[5]  = tbl[3];
        tbl[6]  = '{1,1,0,0,3'd1,1'b1,32'h108,32'h400,1'b0,1'b0,1'b0,32'h108, 0,32'h200,3,1,1};
        tbl[7]  = '{1,0,0,1,3'd0,1'b0,32'hFFFFFFFC,32'h40,1'b0,1'b0,1'b0,32'hFFFFFFFC, 1,32'h40,4,2,0};
        tbl[8]  = '{0,0,0,0,3'd0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,32'hFFFFFFFC, 0,32'h40,4,2,0};
        tbl[9]  = '{1,1,0,0,3'd5,1'b1,32'hFFFFFFFC,32'h1000,1'b1,1'b0,1'b0,32'hFFFFFFFC, 1,32'h0,5,3,0};
        tbl[10] = '{0,0,0,0,3'd0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,32'hFFFFFFFC, 0,32'h0,5,3,0};
        tbl[11] = '{1,1,0,0,3'd2,1'b0,32'h10,32'h80,1'b0,1'b0,1'b0,32'h10, 0,32'h0,6,3,0};
        tbl[12] = '{1,0,1,0,3'd0,1'b1,32'h20,32'h80,1'b0,1'b0,1'b0,32'h20, 0,32'h0,7,3,0};

        // Reset state
        v = '{0,0,0,0,3'd0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0,32'h100, 0,32'h0,0,0,0};
        drive(v);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_flush", 32'({flush_d, flush_e}), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_br_cnt", br_cnt, 32'd0);
        chk("rst_mispred_cnt", mispred_cnt, 32'd0);
        chk("rst_pred_f", 32'(pred_taken_f), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 13; i++) step(tbl[i], 1'b1, 1'b1);

        // Reset asserted during the FLUSH cycle; bht[2] was trained to 10 above.
        v = '{1,1,0,0,3'd0,1'b0,32'h200,32'h500,1'b0,1'b1,1'b0,32'h108, 1,32'h500,8,4,1};
        step(v, 1'b1, 1'b1);
        v.valid = 1'b0;
        drive(v);
        #2 rst_n = 1'b0;
        #1;
        chk("midflush_redirect", 32'(redirect), 32'd0);
        chk("midflush_flush", 32'({flush_d, flush_e}), 32'd0);
        chk("midflush_redirect_pc", redirect_pc, 32'd0);
        chk("midflush_br_cnt", br_cnt, 32'd0);
        chk("midflush_mispred_cnt", mispred_cnt, 32'd0);
        chk("midflush_pred_f", 32'(pred_taken_f), 32'd0);
        $display("txn async reset during FLUSH -> redir=%0d br_cnt=%0d", redirect, br_cnt);
        #3 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        v.valid = 1'b0;
        step(v, 1'b0, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int kind;
            kind    = $urandom_range(0, 5);
            v.valid = ($urandom_range(0, 7) != 0);
            v.br    = (kind <= 2);
            v.jal   = (kind == 3);
            v.jalr  = (kind == 4);
            v.f3    = 3'($urandom_range(0, 7));
            v.pred  = 1'($urandom_range(0, 1));
            v.pc    = {$urandom_range(0, 1) ? 26'h3FFFFFF : 26'($urandom), 4'($urandom), 2'b00};
            v.tgt   = $urandom;
            v.less  = 1'($urandom_range(0, 1));
            v.eq    = 1'($urandom_range(0, 1));
            v.stall = ($urandom_range(0, 4) == 0);
            v.pc_f  = $urandom_range(0, 1) ? v.pc : $urandom;
            step(v, 1'b0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
